// File: rtl/pipe_regfile_pkg.sv
// Shared definitions for the pipe_regfile register-file block.
// Holds default geometry, the value returned for out-of-range reads,
// and the index-width helper used to size every register index.
package pipe_regfile_pkg;

  localparam int DEF_N_REGS   = 8;
  localparam int DEF_DATA_W   = 16;

  // Operand value captured when a read index has no backing register.
  localparam int OOR_READ_VAL = 0;

  // Index width for a given register count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_regfile_rdport.sv
// Single decode-stage read port of pipe_regfile.
// Captures an index and its operand each unstalled cycle; while stalled it
// holds both, refreshing the operand when write-back targets the held index.
// Optional macro PIPE_REGFILE_BYPASS_EN forwards same-edge write-back data
// into the operand capture; without it the stale register value is taken.
module pipe_regfile_rdport
  import pipe_regfile_pkg::*;
#(
  parameter int N_REGS = DEF_N_REGS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = idx_width(DEF_N_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic [IDX_W-1:0]         idx_in,
  input  logic [N_REGS*DATA_W-1:0] reg_flat,
  input  logic                     wb_wen,
  input  logic [IDX_W-1:0]         wb_n_reg,
  input  logic [DATA_W-1:0]        wb_data,
  output logic [IDX_W-1:0]         idx,
  output logic [DATA_W-1:0]        operand
);

  // Every encodable index gets a slot; slots past N_REGS read as the
  // out-of-range value and are flagged invalid so write-back ignores them.
  localparam int N_SLOTS = 1 << IDX_W;

  logic [DATA_W-1:0]  slot [N_SLOTS];
  logic [N_SLOTS-1:0] slot_valid;
  logic               wb_valid;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  capture_data;
  logic [IDX_W-1:0]   idx_reg;
  logic [DATA_W-1:0]  operand_reg;

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      if (gi < N_REGS) begin : g_real
        assign slot[gi]       = reg_flat[gi*DATA_W +: DATA_W];
        assign slot_valid[gi] = 1'b1;
      end else begin : g_pad
        assign slot[gi]       = DATA_W'(OOR_READ_VAL);
        assign slot_valid[gi] = 1'b0;
      end
    end
  endgenerate

  assign wb_valid = wb_wen & slot_valid[wb_n_reg];
  assign rd_data  = slot[idx_in];

  // Select what an unstalled edge captures: register value or forwarded WB data.
  always_comb begin
    capture_data = rd_data;
`ifdef PIPE_REGFILE_BYPASS_EN
    if (wb_valid && (wb_n_reg == idx_in)) begin
      capture_data = wb_data;
    end
`endif
  end

  // Index/operand stage: capture when running, hold with WB refresh when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg     <= '0;
      operand_reg <= '0;
    end else if (!stall) begin
      idx_reg     <= idx_in;
      operand_reg <= capture_data;
    end else if (wb_valid && (wb_n_reg == idx_reg)) begin
      operand_reg <= wb_data;
    end
  end

  assign idx     = idx_reg;
  assign operand = operand_reg;

endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: parametrised register file with two registered decode-stage
// read ports, a write-back port, a one-cycle-delayed destination index and a
// flattened view of all registers.
// Optional macro PIPE_REGFILE_BYPASS_EN enables write-to-read forwarding in
// both read ports (see pipe_regfile_rdport).
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int                N_REGS    = DEF_N_REGS,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               IDX_W     = idx_width(N_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [IDX_W-1:0]         N_REG_A_IN,
  input  logic [IDX_W-1:0]         N_REG_B_IN,
  input  logic                     STALL,
  input  logic                     WB_WEN,
  input  logic [IDX_W-1:0]         WB_N_REG,
  input  logic [DATA_W-1:0]        WB_DATA,
  output logic [IDX_W-1:0]         N_REG_A,
  output logic [DATA_W-1:0]        REG_A,
  output logic [DATA_W-1:0]        REG_B,
  output logic [IDX_W-1:0]         N_REG_A_DLY,
  output logic [N_REGS*DATA_W-1:0] REG_FLAT
);

  logic [IDX_W-1:0] n_reg_b_unused;
  logic [IDX_W-1:0] n_reg_a_dly_reg;

  // One storage register per architectural index; an index with no
  // matching register simply never enables any write.
  generate
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      // Write-back into this register when its index is addressed.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          q_reg <= RESET_VAL;
        end else if (WB_WEN && (WB_N_REG == IDX_W'(gi))) begin
          q_reg <= WB_DATA;
        end
      end

      assign REG_FLAT[gi*DATA_W +: DATA_W] = q_reg;
    end
  endgenerate

  pipe_regfile_rdport #(
    .N_REGS (N_REGS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_port_a (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .stall    (STALL),
    .idx_in   (N_REG_A_IN),
    .reg_flat (REG_FLAT),
    .wb_wen   (WB_WEN),
    .wb_n_reg (WB_N_REG),
    .wb_data  (WB_DATA),
    .idx      (N_REG_A),
    .operand  (REG_A)
  );

  pipe_regfile_rdport #(
    .N_REGS (N_REGS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_port_b (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .stall    (STALL),
    .idx_in   (N_REG_B_IN),
    .reg_flat (REG_FLAT),
    .wb_wen   (WB_WEN),
    .wb_n_reg (WB_N_REG),
    .wb_data  (WB_DATA),
    .idx      (n_reg_b_unused),
    .operand  (REG_B)
  );

  // EX-to-WB destination index delay; frozen together with the decode stage.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      n_reg_a_dly_reg <= '0;
    end else if (!STALL) begin
      n_reg_a_dly_reg <= N_REG_A;
    end
  end

  assign N_REG_A_DLY = n_reg_a_dly_reg;

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: a default 8x16 instance checked every
// cycle against a behavioural model, plus 6x16 and 16x32 instances for the
// out-of-range and wide-configuration cases, all with literal expectations.
module tb_pipe_regfile;

`ifdef PIPE_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance 8 x 16
  logic [2:0]   a_in = '0, b_in = '0, widx = '0;
  logic         stall = 1'b0, wen = 1'b0;
  logic [15:0]  wdata = '0;
  logic [2:0]   na, dly;
  logic [15:0]  ra, rb;
  logic [127:0] flat;

  pipe_regfile u_dut (
    .CLK(clk), .RESET_N(rst_n), .N_REG_A_IN(a_in), .N_REG_B_IN(b_in),
    .STALL(stall), .WB_WEN(wen), .WB_N_REG(widx), .WB_DATA(wdata),
    .N_REG_A(na), .REG_A(ra), .REG_B(rb), .N_REG_A_DLY(dly), .REG_FLAT(flat)
  );

  // Instance 6 x 16 (indices 6 and 7 have no register)
  logic [2:0]  a6 = '0, b6 = '0, widx6 = '0;
  logic        wen6 = 1'b0, stall6 = 1'b0;
  logic [15:0] wdata6 = '0;
  logic [2:0]  na6, dly6;
  logic [15:0] ra6, rb6;
  logic [95:0] flat6;

  pipe_regfile #(.N_REGS(6), .DATA_W(16)) u_dut6 (
    .CLK(clk), .RESET_N(rst_n), .N_REG_A_IN(a6), .N_REG_B_IN(b6),
    .STALL(stall6), .WB_WEN(wen6), .WB_N_REG(widx6), .WB_DATA(wdata6),
    .N_REG_A(na6), .REG_A(ra6), .REG_B(rb6), .N_REG_A_DLY(dly6), .REG_FLAT(flat6)
  );

  // Instance 16 x 32
  logic [3:0]   a16 = '0, b16 = '0, widx16 = '0;
  logic         wen16 = 1'b0, stall16 = 1'b0;
  logic [31:0]  wdata16 = '0;
  logic [3:0]   na16, dly16;
  logic [31:0]  ra16, rb16;
  logic [511:0] flat16;

  pipe_regfile #(.N_REGS(16), .DATA_W(32)) u_dut16 (
    .CLK(clk), .RESET_N(rst_n), .N_REG_A_IN(a16), .N_REG_B_IN(b16),
    .STALL(stall16), .WB_WEN(wen16), .WB_N_REG(widx16), .WB_DATA(wdata16),
    .N_REG_A(na16), .REG_A(ra16), .REG_B(rb16), .N_REG_A_DLY(dly16), .REG_FLAT(flat16)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp, input bit verbose);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else if (verbose) begin
      $display("check %s ok: %0h", name, act);
    end
  endtask

  // Behavioural model of the 8x16 instance: an array of registers plus the
  // architectural pipeline latches, updated once per clock edge.
  logic [15:0] m_mem [8];
  logic [2:0]  m_na = '0, m_nb = '0, m_dly = '0;
  logic [15:0] m_a = '0, m_b = '0;

  function automatic logic [15:0] m_read(input logic [2:0] i);
    if (BYP && wen && (widx == i)) return wdata;
    return m_mem[i];
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_na = '0; m_nb = '0; m_dly = '0; m_a = '0; m_b = '0;
      end else begin
        if (!stall) begin
          m_dly = m_na;
          m_na  = a_in;
          m_nb  = b_in;
          m_a   = m_read(a_in);
          m_b   = m_read(b_in);
        end else begin
          if (wen && (widx == m_na)) m_a = wdata;
          if (wen && (widx == m_nb)) m_b = wdata;
        end
        if (wen) m_mem[widx] = wdata;
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  initial begin
    logic [127:0] m_flat;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) m_flat[i*16 +: 16] = m_mem[i];
      chk("m_n_reg_a", na,   m_na,   1'b0);
      chk("m_n_reg_a_dly", dly, m_dly, 1'b0);
      chk("m_reg_a",   ra,   m_a,    1'b0);
      chk("m_reg_b",   rb,   m_b,    1'b0);
      chk("m_reg_flat", flat, m_flat, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [2:0] a, input logic [2:0] b, input logic st,
                     input logic we, input logic [2:0] wi, input logic [15:0] wd);
    a_in = a; b_in = b; stall = st; wen = we; widx = wi; wdata = wd;
    tick();
    $display("cycle a_in=%0d b_in=%0d stall=%0b wen=%0b widx=%0d wdata=%h -> na=%0d ra=%h rb=%h dly=%0d",
             a, b, st, we, wi, wd, na, ra, rb, dly);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_reg_a", ra, 16'h0, 1'b1);
    chk("rst_n_reg_a_dly", dly, 3'd0, 1'b1);
    chk("rst_flat", flat, 128'h0, 1'b1);
    chk("rst_n_reg_a6", na6, 3'd0, 1'b1);
    chk("rst_n_reg_a_dly16", dly16, 4'd0, 1'b1);
    rst_n = 1'b1;

    // Write/read latency
    drv(0, 0, 0, 1, 3, 16'h1234);
    chk("flat_r3", flat[63:48], 16'h1234, 1'b1);
    drv(3, 3, 0, 0, 0, 16'h0);
    chk("lat_reg_a", ra, 16'h1234, 1'b1);
    chk("lat_reg_b", rb, 16'h1234, 1'b1);
    chk("lat_n_reg_a", na, 3'd3, 1'b1);
    drv(0, 0, 0, 0, 0, 16'h0);
    chk("lat_dly", dly, 3'd3, 1'b1);

    // Same-edge hazard
    drv(0, 0, 0, 1, 5, 16'h0001);
    drv(0, 5, 0, 1, 5, 16'hBEEF);
    chk("hazard_reg_b", rb, BYP ? 16'hBEEF : 16'h0001, 1'b1);
    drv(5, 5, 0, 0, 0, 16'h0);
    chk("after_hazard_a", ra, 16'hBEEF, 1'b1);
    chk("after_hazard_b", rb, 16'hBEEF, 1'b1);

    // Stall hold and refresh
    drv(0, 0, 0, 1, 2, 16'h0011);
    drv(2, 4, 0, 0, 0, 16'h0);
    chk("pre_stall_a", ra, 16'h0011, 1'b1);
    chk("pre_stall_dly", dly, 3'd0, 1'b1);
    drv(7, 6, 1, 1, 2, 16'h0022);
    chk("stall_refresh_a", ra, 16'h0022, 1'b1);
    chk("stall_hold_na", na, 3'd2, 1'b1);
    drv(7, 6, 1, 1, 4, 16'h0044);
    chk("stall_keep_a", ra, 16'h0022, 1'b1);
    chk("stall_refresh_b", rb, 16'h0044, 1'b1);
    chk("stall_hold_dly", dly, 3'd0, 1'b1);
    drv(4, 2, 0, 0, 0, 16'h0);
    chk("resume_a", ra, 16'h0044, 1'b1);
    chk("resume_b", rb, 16'h0022, 1'b1);
    chk("resume_dly", dly, 3'd2, 1'b1);

    // Reset asserted during a stalled write
    a_in = 1; b_in = 1; stall = 1; wen = 1; widx = 6; wdata = 16'h0066;
    rst_n = 1'b0;
    #1;
    chk("midrst_reg_a", ra, 16'h0, 1'b1);
    chk("midrst_n_reg_a", na, 3'd0, 1'b1);
    chk("midrst_flat", flat, 128'h0, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv(3'(i), 3'(7 - i), 0, 0, 0, 16'h0);
      chk("postrst_a", ra, 16'h0, 1'b1);
      chk("postrst_b", rb, 16'h0, 1'b1);
      if (i == 0) chk("postrst_dly", dly, 3'd0, 1'b1);
    end

    // Mixed traffic, checked cycle by cycle against the model
    for (int i = 0; i < 24; i++) begin
      drv(3'((i * 3) % 8), 3'((i * 5 + 1) % 8), (i % 5) == 3, (i % 3) != 1,
          3'((i * 7) % 8), 16'(16'h1000 + i * 16'h0101));
    end
    wen = 1'b0; stall = 1'b0;

    // Out-of-range handling on the 6-register instance
    wen6 = 1; widx6 = 7; wdata6 = 16'hFFFF; tick();
    chk("oor_write7_flat", flat6, 96'h0, 1'b1);
    widx6 = 6; tick();
    chk("oor_write6_flat", flat6, 96'h0, 1'b1);
    widx6 = 5; wdata6 = 16'hABCD; tick();
    chk("r5_flat6", flat6[95:80], 16'hABCD, 1'b1);
    wen6 = 0; a6 = 7; b6 = 5; tick();
    chk("oor_read_a", ra6, 16'h0, 1'b1);
    chk("r5_read_b", rb6, 16'hABCD, 1'b1);
    wen6 = 1; widx6 = 7; wdata6 = 16'hFFFF; a6 = 7; b6 = 7; tick();
    chk("oor_no_fwd_a", ra6, 16'h0, 1'b1);
    chk("oor_no_fwd_b", rb6, 16'h0, 1'b1);
    wen6 = 0;

    // Wide 16 x 32 instance
    chk("wide_pre", flat16[511:480], 32'h0, 1'b1);
    wen16 = 1; widx16 = 15; wdata16 = 32'hDEADBEEF; tick();
    chk("wide_flat_r15", flat16[511:480], 32'hDEADBEEF, 1'b1);
    wen16 = 0; a16 = 15; b16 = 15; tick();
    chk("wide_reg_a", ra16, 32'hDEADBEEF, 1'b1);
    chk("wide_reg_b", rb16, 32'hDEADBEEF, 1'b1);
    chk("wide_n_reg_a", na16, 4'd15, 1'b1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
